// File: rtl/mae_pipe_macc_if.sv
// ----------------------------------------------------------------------------
// mae_pipe_macc_if
//   Beat/result bundle for the mae_pipe_macc multiply-add/accumulate engine.
//
//   Parameters: A_WIDTH, B_WIDTH, C_WIDTH, P_WIDTH (must match the engine).
//
//   Signals:
//     en         global clock enable for the engine
//     in_valid   beat valid
//     mode       0=MULT, 1=MADD, 2=MACC, 3=MACC_LOAD
//     a, b       multiplier operands
//     c          addend / accumulator preload
//     p          result register
//     out_valid  p was updated by a valid beat this cycle
//     ovf        sticky overflow flag (saturation build only, else 0)
//
//   Modports: master drives the beats (source side), slave is the engine.
// ----------------------------------------------------------------------------
interface mae_pipe_macc_if #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int C_WIDTH = 40,
    parameter int P_WIDTH = 40
);
    logic               en;
    logic               in_valid;
    logic [1:0]         mode;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic [C_WIDTH-1:0] c;
    logic [P_WIDTH-1:0] p;
    logic               out_valid;
    logic               ovf;

    modport master (
        output en, in_valid, mode, a, b, c,
        input  p, out_valid, ovf
    );

    modport slave (
        input  en, in_valid, mode, a, b, c,
        output p, out_valid, ovf
    );
endinterface

// File: rtl/mae_pipe_macc.sv
// ----------------------------------------------------------------------------
// mae_pipe_macc
//   Parametrised multiply-add/accumulate engine. Each beat carries its own
//   mode, which travels down the pipeline with the operands:
//     MULT      P <= A*B
//     MADD      P <= A*B + C
//     MACC      P <= P + A*B
//     MACC_LOAD P <= C + A*B   (starts a new accumulation)
//   Latency from an accepted beat to out_valid is REG_IN + REG_M + 1.
//
//   Ports:
//     clk   rising-edge clock
//     srst  synchronous active-high reset (beats in flight are discarded)
//     bus   mae_pipe_macc_if.slave: en, in_valid, mode, a, b, c -> p,
//           out_valid, ovf
//
//   Build option: define MAE_PIPE_MACC_SATURATE_EN to clamp out-of-range
//   results and raise the sticky ovf flag. Without it results wrap modulo
//   2^P_WIDTH and ovf is tied to 0.
// ----------------------------------------------------------------------------
module mae_pipe_macc #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int C_WIDTH = 40,
    parameter int P_WIDTH = 40,
    parameter bit SIGNED  = 1'b1,
    parameter int REG_IN  = 1,
    parameter int REG_M   = 1
) (
    input  logic            clk,
    input  logic            srst,
    mae_pipe_macc_if.slave  bus
);
    localparam int AB_WIDTH = A_WIDTH + B_WIDTH;
    // One guard bit above P so every sum is exact before wrap/clamp.
    localparam int X_WIDTH  = P_WIDTH + 1;

    localparam logic [1:0] MODE_MULT      = 2'd0;
    localparam logic [1:0] MODE_MADD      = 2'd1;
    localparam logic [1:0] MODE_MACC      = 2'd2;
    localparam logic [1:0] MODE_MACC_LOAD = 2'd3;

    if (P_WIDTH < AB_WIDTH) begin : g_bad_p_width
        $error("mae_pipe_macc: P_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
    if (C_WIDTH > P_WIDTH) begin : g_bad_c_width
        $error("mae_pipe_macc: C_WIDTH must be <= P_WIDTH");
    end
    if (REG_M < 0 || REG_M > 2 || REG_IN < 0 || REG_IN > 1) begin : g_bad_depth
        $error("mae_pipe_macc: REG_IN must be 0..1 and REG_M 0..2");
    end

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [A_WIDTH-1:0] a_s1;
    logic [B_WIDTH-1:0] b_s1;
    logic [C_WIDTH-1:0] c_s1;
    logic [1:0]         mode_s1;
    logic               valid_s1;

    if (REG_IN != 0) begin : g_in_reg
        logic [A_WIDTH-1:0] a_reg;
        logic [B_WIDTH-1:0] b_reg;
        logic [C_WIDTH-1:0] c_reg;
        logic [1:0]         mode_reg;
        logic               valid_reg;

        always_ff @(posedge clk) begin
            if (srst) begin
                a_reg     <= '0;
                b_reg     <= '0;
                c_reg     <= '0;
                mode_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (bus.en) begin
                a_reg     <= bus.a;
                b_reg     <= bus.b;
                c_reg     <= bus.c;
                mode_reg  <= bus.mode;
                valid_reg <= bus.in_valid;
            end
        end

        assign a_s1     = a_reg;
        assign b_s1     = b_reg;
        assign c_s1     = c_reg;
        assign mode_s1  = mode_reg;
        assign valid_s1 = valid_reg;
    end else begin : g_in_comb
        assign a_s1     = bus.a;
        assign b_s1     = bus.b;
        assign c_s1     = bus.c;
        assign mode_s1  = bus.mode;
        assign valid_s1 = bus.in_valid;
    end

    // ------------------------------------------------------------------
    // Multiplier. Operands are extended to the full product width so an
    // unsigned multiply yields the correct low AB_WIDTH bits in both the
    // signed and unsigned builds.
    // ------------------------------------------------------------------
    logic [AB_WIDTH-1:0] a_ext;
    logic [AB_WIDTH-1:0] b_ext;
    logic [AB_WIDTH-1:0] prod;
    logic [X_WIDTH-1:0]  m_x;
    logic [X_WIDTH-1:0]  c_x;

    assign a_ext = {{B_WIDTH{SIGNED & a_s1[A_WIDTH-1]}}, a_s1};
    assign b_ext = {{A_WIDTH{SIGNED & b_s1[B_WIDTH-1]}}, b_s1};
    assign prod  = a_ext * b_ext;
    assign m_x   = {{(X_WIDTH-AB_WIDTH){SIGNED & prod[AB_WIDTH-1]}}, prod};
    assign c_x   = {{(X_WIDTH-C_WIDTH){SIGNED & c_s1[C_WIDTH-1]}}, c_s1};

    // ------------------------------------------------------------------
    // Multiplier pipeline; C, mode and valid are delay-matched to M.
    // ------------------------------------------------------------------
    logic [X_WIDTH-1:0] m_p;
    logic [X_WIDTH-1:0] c_p;
    logic [1:0]         mode_p;
    logic               valid_p;

    if (REG_M > 0) begin : g_m_reg
        logic [X_WIDTH-1:0] m_reg     [REG_M];
        logic [X_WIDTH-1:0] c_reg     [REG_M];
        logic [1:0]         mode_reg  [REG_M];
        logic               valid_reg [REG_M];

        always_ff @(posedge clk) begin
            if (srst) begin
                for (int i = 0; i < REG_M; i++) begin
                    m_reg[i]     <= '0;
                    c_reg[i]     <= '0;
                    mode_reg[i]  <= '0;
                    valid_reg[i] <= 1'b0;
                end
            end else if (bus.en) begin
                m_reg[0]     <= m_x;
                c_reg[0]     <= c_x;
                mode_reg[0]  <= mode_s1;
                valid_reg[0] <= valid_s1;
                for (int i = 1; i < REG_M; i++) begin
                    m_reg[i]     <= m_reg[i-1];
                    c_reg[i]     <= c_reg[i-1];
                    mode_reg[i]  <= mode_reg[i-1];
                    valid_reg[i] <= valid_reg[i-1];
                end
            end
        end

        assign m_p     = m_reg[REG_M-1];
        assign c_p     = c_reg[REG_M-1];
        assign mode_p  = mode_reg[REG_M-1];
        assign valid_p = valid_reg[REG_M-1];
    end else begin : g_m_comb
        assign m_p     = m_x;
        assign c_p     = c_x;
        assign mode_p  = mode_s1;
        assign valid_p = valid_s1;
    end

    // ------------------------------------------------------------------
    // Post-adder / P stage. MACC reads P itself, so back-to-back MACC
    // beats always see the previous beat's result without forwarding.
    // ------------------------------------------------------------------
    logic [P_WIDTH-1:0] p_reg;
    logic               out_valid_reg;
    logic [X_WIDTH-1:0] p_x;
    logic [X_WIDTH-1:0] sum;
    logic [P_WIDTH-1:0] p_next;
    logic               p_load;

    assign p_x    = {SIGNED & p_reg[P_WIDTH-1], p_reg};
    assign p_load = bus.en & valid_p;

    always_comb begin
        sum = m_p;
        case (mode_p)
            MODE_MULT:      sum = m_p;
            MODE_MADD:      sum = m_p + c_p;
            MODE_MACC:      sum = p_x + m_p;
            MODE_MACC_LOAD: sum = c_p + m_p;
            default:        sum = m_p;
        endcase
    end

`ifdef MAE_PIPE_MACC_SATURATE_EN
    logic sum_ovf;
    logic ovf_reg;

    // Signed: guard bit disagreeing with the P sign bit means out of range;
    // the guard bit itself gives the direction. Unsigned can only overflow
    // upwards.
    always_comb begin
        sum_ovf = SIGNED ? (sum[P_WIDTH] ^ sum[P_WIDTH-1]) : sum[P_WIDTH];
        p_next  = sum[P_WIDTH-1:0];
        if (sum_ovf) begin
            if (SIGNED) begin
                p_next = sum[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                      : {1'b0, {(P_WIDTH-1){1'b1}}};
            end else begin
                p_next = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ovf_reg <= 1'b0;
        end else if (p_load && sum_ovf) begin
            ovf_reg <= 1'b1;
        end
    end

    assign bus.ovf = ovf_reg;
`else
    logic sum_guard_unused;

    // Wrapping build: the guard bit is simply dropped.
    assign sum_guard_unused = sum[P_WIDTH];
    assign p_next           = sum[P_WIDTH-1:0];
    assign bus.ovf          = 1'b0;
`endif

    // out_valid is a one-cycle update strobe, so it drops after any cycle
    // with en low even though the valid pipeline itself is frozen.
    always_ff @(posedge clk) begin
        if (srst) begin
            p_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= p_load;
            if (p_load) begin
                p_reg <= p_next;
            end
        end
    end

    assign bus.p         = p_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_mae_pipe_macc.sv
// ----------------------------------------------------------------------------
// tb_mae_pipe_macc
//   Directed bench for mae_pipe_macc. The default-parameter engine (L=3) is
//   exercised from a per-cycle vector table; reset, sweep (L=1 and L=4,
//   unsigned) and reset-during-accumulation are hand-written sequences.
//   Each table row gives the inputs driven for one cycle and the outputs
//   expected just after that cycle's clock edge.
// ----------------------------------------------------------------------------
module tb_mae_pipe_macc;
    logic clk = 1'b0;
    logic srst;

    always #5 clk = ~clk;

    mae_pipe_macc_if #(.A_WIDTH(18), .B_WIDTH(18), .C_WIDTH(40), .P_WIDTH(40)) bus0 ();
    mae_pipe_macc_if #(.A_WIDTH(18), .B_WIDTH(18), .C_WIDTH(40), .P_WIDTH(40)) bus1 ();
    mae_pipe_macc_if #(.A_WIDTH(18), .B_WIDTH(18), .C_WIDTH(40), .P_WIDTH(40)) bus4 ();

    mae_pipe_macc u_dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus0)
    );

    mae_pipe_macc #(.SIGNED(1'b0), .REG_IN(0), .REG_M(0)) u_dut_l1 (
        .clk  (clk),
        .srst (srst),
        .bus  (bus1)
    );

    mae_pipe_macc #(.SIGNED(1'b0), .REG_IN(1), .REG_M(2)) u_dut_l4 (
        .clk  (clk),
        .srst (srst),
        .bus  (bus4)
    );

`ifdef MAE_PIPE_MACC_SATURATE_EN
    localparam logic [39:0] OVF_P   = 40'h7F_FFFF_FFFF;
    localparam logic        OVF_BIT = 1'b1;
`else
    localparam logic [39:0] OVF_P   = 40'h80_0000_0000;
    localparam logic        OVF_BIT = 1'b0;
`endif

    typedef struct {
        logic [1:0]  mode;
        logic [17:0] a;
        logic [17:0] b;
        logic [39:0] c;
        logic        v;
        logic        en;
        logic        x_ov;
        logic [39:0] x_p;
        logic        x_ovf;
    } vec_t;

    localparam int NVEC = 30;
    vec_t tbl [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic [1:0] m, input logic [17:0] a,
                                input logic [17:0] b, input logic [39:0] c,
                                input logic v, input logic en, input logic xo,
                                input logic [39:0] xp, input logic xf);
        vec_t r;
        r.mode = m; r.a = a; r.b = b; r.c = c; r.v = v; r.en = en;
        r.x_ov = xo; r.x_p = xp; r.x_ovf = xf;
        return r;
    endfunction

    function automatic vec_t bub(input logic xo, input logic [39:0] xp, input logic xf);
        return mk(2'd0, 18'd0, 18'd0, 40'd0, 1'b0, 1'b1, xo, xp, xf);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [1:0] m, input logic [17:0] a, input logic [17:0] b,
                          input logic [39:0] c, input logic v, input logic en);
        bus0.mode = m; bus0.a = a; bus0.b = b; bus0.c = c;
        bus0.in_valid = v; bus0.en = en;
    endtask

    initial begin
        drive0(2'd0, 18'd0, 18'd0, 40'd0, 1'b0, 1'b1);
        bus1.mode = 2'd0; bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.in_valid = 1'b0; bus1.en = 1'b1;
        bus4.mode = 2'd0; bus4.a = '0; bus4.b = '0; bus4.c = '0; bus4.in_valid = 1'b0; bus4.en = 1'b1;
        srst = 1'b1;

        // MULT 3*-4, back-to-back MACC, MACC with gap and 2-cycle stall,
        // MADD followed by MACC, overflow MADD then MULT.
        tbl[0]  = mk(2'd0, 18'd3, 18'(-4), 40'd0, 1'b1, 1'b1, 1'b0, 40'd0, 1'b0);
        tbl[1]  = bub(1'b0, 40'd0, 1'b0);
        tbl[2]  = bub(1'b1, 40'hFF_FFFF_FFF4, 1'b0);
        tbl[3]  = mk(2'd3, 18'd2, 18'd5, 40'd100, 1'b1, 1'b1, 1'b0, 40'hFF_FFFF_FFF4, 1'b0);
        tbl[4]  = mk(2'd2, 18'd1, 18'd1, 40'd0, 1'b1, 1'b1, 1'b0, 40'hFF_FFFF_FFF4, 1'b0);
        tbl[5]  = mk(2'd2, 18'd1, 18'd1, 40'd0, 1'b1, 1'b1, 1'b1, 40'd110, 1'b0);
        tbl[6]  = mk(2'd2, 18'd1, 18'd1, 40'd0, 1'b1, 1'b1, 1'b1, 40'd111, 1'b0);
        tbl[7]  = bub(1'b1, 40'd112, 1'b0);
        tbl[8]  = bub(1'b1, 40'd113, 1'b0);
        tbl[9]  = bub(1'b0, 40'd113, 1'b0);
        tbl[10] = mk(2'd3, 18'd2, 18'd5, 40'd100, 1'b1, 1'b1, 1'b0, 40'd113, 1'b0);
        tbl[11] = mk(2'd2, 18'd1, 18'd1, 40'd0, 1'b1, 1'b1, 1'b0, 40'd113, 1'b0);
        tbl[12] = bub(1'b1, 40'd110, 1'b0);
        tbl[13] = mk(2'd2, 18'd1, 18'd1, 40'd0, 1'b1, 1'b1, 1'b1, 40'd111, 1'b0);
        tbl[14] = mk(2'd2, 18'd1, 18'd1, 40'd0, 1'b1, 1'b0, 1'b0, 40'd111, 1'b0);
        tbl[15] = mk(2'd2, 18'd1, 18'd1, 40'd0, 1'b1, 1'b0, 1'b0, 40'd111, 1'b0);
        tbl[16] = mk(2'd2, 18'd1, 18'd1, 40'd0, 1'b1, 1'b1, 1'b0, 40'd111, 1'b0);
        tbl[17] = bub(1'b1, 40'd112, 1'b0);
        tbl[18] = bub(1'b1, 40'd113, 1'b0);
        tbl[19] = bub(1'b0, 40'd113, 1'b0);
        tbl[20] = mk(2'd1, 18'(-2), 18'd7, 40'd20, 1'b1, 1'b1, 1'b0, 40'd113, 1'b0);
        tbl[21] = mk(2'd2, 18'd3, 18'd3, 40'd0, 1'b1, 1'b1, 1'b0, 40'd113, 1'b0);
        tbl[22] = bub(1'b1, 40'd6, 1'b0);
        tbl[23] = bub(1'b1, 40'd15, 1'b0);
        tbl[24] = bub(1'b0, 40'd15, 1'b0);
        tbl[25] = mk(2'd1, 18'd1, 18'd1, 40'h7F_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 40'd15, 1'b0);
        tbl[26] = mk(2'd0, 18'd1, 18'd1, 40'd0, 1'b1, 1'b1, 1'b0, 40'd15, 1'b0);
        tbl[27] = bub(1'b1, OVF_P, OVF_BIT);
        tbl[28] = bub(1'b1, 40'd1, OVF_BIT);
        tbl[29] = bub(1'b0, 40'd1, OVF_BIT);

        // Reset state
        step();
        step();
        check("rst_p", 64'(bus0.p), 64'd0);
        check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst_ovf", 64'(bus0.ovf), 64'd0);
        check("rst_p_l1", 64'(bus1.p), 64'd0);
        check("rst_p_l4", 64'(bus4.p), 64'd0);
        srst = 1'b0;

        // Table-driven stream on the L=3 engine
        for (int i = 0; i < NVEC; i++) begin
            drive0(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].v, tbl[i].en);
            step();
            check($sformatf("vec%0d_out_valid", i), 64'(bus0.out_valid), 64'(tbl[i].x_ov));
            check($sformatf("vec%0d_p", i), 64'(bus0.p), 64'(tbl[i].x_p));
            check($sformatf("vec%0d_ovf", i), 64'(bus0.ovf), 64'(tbl[i].x_ovf));
            $display("vec %0d: mode=%0d v=%0b en=%0b -> out_valid=%0b p=%0h ovf=%0b",
                     i, tbl[i].mode, tbl[i].v, tbl[i].en, bus0.out_valid, bus0.p, bus0.ovf);
        end

        // Reset while two MACC beats are in flight; a beat presented together
        // with reset must be dropped as well.
        drive0(2'd2, 18'd1, 18'd1, 40'd0, 1'b1, 1'b1);
        step();
        step();
        srst = 1'b1;
        drive0(2'd2, 18'd7, 18'd7, 40'd0, 1'b1, 1'b1);
        step();
        srst = 1'b0;
        check("midrst_p", 64'(bus0.p), 64'd0);
        check("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("midrst_ovf", 64'(bus0.ovf), 64'd0);
        drive0(2'd0, 18'd0, 18'd0, 40'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("midrst_drop%0d_out_valid", k), 64'(bus0.out_valid), 64'd0);
            check($sformatf("midrst_drop%0d_p", k), 64'(bus0.p), 64'd0);
        end
        drive0(2'd2, 18'd2, 18'd3, 40'd0, 1'b1, 1'b1);
        step();
        drive0(2'd0, 18'd0, 18'd0, 40'd0, 1'b0, 1'b1);
        step();
        step();
        check("after_rst_macc_out_valid", 64'(bus0.out_valid), 64'd1);
        check("after_rst_macc_p", 64'(bus0.p), 64'd6);
        $display("reset mid-accumulation: MACC 2*3 -> p=%0h", bus0.p);

        // Reset has priority over a deasserted enable.
        drive0(2'd0, 18'd0, 18'd0, 40'd0, 1'b0, 1'b0);
        srst = 1'b1;
        step();
        srst = 1'b0;
        check("rst_over_en_p", 64'(bus0.p), 64'd0);
        drive0(2'd0, 18'd0, 18'd0, 40'd0, 1'b0, 1'b1);

        // Parameter sweep: unsigned MULT 0x3FFFF^2 then MACC of the same.
        bus1.mode = 2'd0; bus1.a = 18'h3FFFF; bus1.b = 18'h3FFFF; bus1.in_valid = 1'b1;
        bus4.mode = 2'd0; bus4.a = 18'h3FFFF; bus4.b = 18'h3FFFF; bus4.in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin
                bus1.mode = 2'd2;
                bus4.mode = 2'd2;
            end else begin
                bus1.in_valid = 1'b0;
                bus4.in_valid = 1'b0;
            end
            check($sformatf("l1_k%0d_out_valid", k), 64'(bus1.out_valid),
                  (k == 1 || k == 2) ? 64'd1 : 64'd0);
            check($sformatf("l1_k%0d_p", k), 64'(bus1.p),
                  (k == 1) ? 64'h0F_FFF8_0001 : 64'h1F_FFF0_0002);
            check($sformatf("l4_k%0d_out_valid", k), 64'(bus4.out_valid),
                  (k == 4 || k == 5) ? 64'd1 : 64'd0);
            check($sformatf("l4_k%0d_p", k), 64'(bus4.p),
                  (k < 4) ? 64'd0 : ((k == 4) ? 64'h0F_FFF8_0001 : 64'h1F_FFF0_0002));
            $display("sweep k=%0d: l1 out_valid=%0b p=%0h | l4 out_valid=%0b p=%0h",
                     k, bus1.out_valid, bus1.p, bus4.out_valid, bus4.p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
